// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between
// NUM_REQ requesters. One operation is accepted per handshake. It runs on the
// ALU for one cycle, and its result returns on a tagged valid/ready channel.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*5-1:0]          req_op_i,
  output logic [DATA_WIDTH-1:0]         alu_a_o,
  output logic [DATA_WIDTH-1:0]         alu_b_o,
  output logic [4:0]                    alu_op_o,
  input  logic [DATA_WIDTH-1:0]         alu_c_i,
  input  logic                          alu_cmp_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [DATA_WIDTH-1:0]         resp_data_o,
  output logic                          resp_cmp_o,
  output logic [ID_W-1:0]               resp_id_o,
  output logic                          resp_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [4:0]            r_op;
  logic [ID_W-1:0]       r_id;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_cmp;
  logic [ID_W-1:0]       r_resp_id;
  logic                  r_resp_err;

  // Rotate the valid vector so the pointer position becomes bit 0, pick the
  // lowest set bit, then rotate the one-hot pick back to absolute positions.
  logic [2*NUM_REQ-1:0] w_valid_dbl;
  logic [2*NUM_REQ-1:0] w_valid_shift;
  logic [NUM_REQ-1:0]   w_valid_rot;
  logic [NUM_REQ-1:0]   w_first;
  logic [2*NUM_REQ-1:0] w_first_dbl;
  logic [NUM_REQ-1:0]   w_sel;
  logic [ID_W-1:0]      w_win;
  logic                 w_any;
  logic                 w_fire;
  logic                 w_window;
  logic                 w_hs;
  logic                 w_illegal;

  assign w_valid_dbl   = {req_valid_i, req_valid_i};
  assign w_valid_shift = w_valid_dbl >> r_ptr;
  assign w_valid_rot   = w_valid_shift[NUM_REQ-1:0];

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_first
      if (gi == 0) begin : g_lsb
        assign w_first[gi] = w_valid_rot[gi];
      end else begin : g_rest
        assign w_first[gi] = w_valid_rot[gi] & ~(|w_valid_rot[gi-1:0]);
      end
    end
  endgenerate

  assign w_first_dbl = {{NUM_REQ{1'b0}}, w_first} << r_ptr;
  assign w_sel       = w_first_dbl[NUM_REQ-1:0] | w_first_dbl[2*NUM_REQ-1:NUM_REQ];

  // Binary index of the one-hot winner: each index bit ORs the selects whose
  // position has that bit set.
  generate
    for (gb = 0; gb < ID_W; gb++) begin : g_enc
      logic [NUM_REQ-1:0] w_terms;
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_term
        assign w_terms[gi] = w_sel[gi] & (((gi >> gb) & 1) == 1);
      end
      assign w_win[gb] = |w_terms;
    end
  endgenerate

  // AND-OR payload mux driven by the one-hot winner.
  logic [DATA_WIDTH-1:0] w_a_acc  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b_acc  [NUM_REQ];
  logic [4:0]            w_op_acc [NUM_REQ];
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mux
      if (gi == 0) begin : g_base
        assign w_a_acc[gi]  = req_a_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_sel[gi]}};
        assign w_b_acc[gi]  = req_b_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_sel[gi]}};
        assign w_op_acc[gi] = req_op_i[gi*5 +: 5] & {5{w_sel[gi]}};
      end else begin : g_chain
        assign w_a_acc[gi]  = w_a_acc[gi-1]  | (req_a_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_sel[gi]}});
        assign w_b_acc[gi]  = w_b_acc[gi-1]  | (req_b_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_sel[gi]}});
        assign w_op_acc[gi] = w_op_acc[gi-1] | (req_op_i[gi*5 +: 5] & {5{w_sel[gi]}});
      end
    end
  endgenerate

  // A new request may enter when idle, or when the pending response leaves
  // in this very cycle.
  assign w_any     = |req_valid_i;
  assign w_fire    = (r_state == S_RESP) & resp_ready_i;
  assign w_window  = (r_state == S_IDLE) | w_fire;
  assign w_hs      = w_window & w_any;
  assign w_illegal = (r_op > 5'd16);

  assign req_ready_o  = w_sel & {NUM_REQ{w_window}};
  assign alu_a_o      = r_a;
  assign alu_b_o      = r_b;
  assign alu_op_o     = r_op;
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_cmp_o   = r_resp_cmp;
  assign resp_id_o    = r_resp_id;
  assign resp_err_o   = r_resp_err;

  // Control FSM: accept, run the ALU for one cycle, hold the response until taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_cmp   <= 1'b0;
      r_resp_id    <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_a   <= w_a_acc[NUM_REQ-1];
        r_b   <= w_b_acc[NUM_REQ-1];
        r_op  <= w_op_acc[NUM_REQ-1];
        r_id  <= w_win;
        r_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_hs) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_resp_data  <= w_illegal ? '0 : alu_c_i;
          r_resp_cmp   <= w_illegal ? 1'b0 : alu_cmp_i;
          r_resp_err   <= w_illegal;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (w_fire) begin
            r_resp_valid <= 1'b0;
            r_state      <= w_hs ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. The bench also plays the ALU.
// Directed vectors, hand-written corner sequences, and a randomized run
// against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int DW = 64;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*5-1:0]  req_op;
  logic [DW-1:0]   alu_a, alu_b, alu_c;
  logic [4:0]      alu_op;
  logic            alu_cmp;
  logic            resp_valid, resp_ready, resp_cmp, resp_err;
  logic [DW-1:0]   resp_data;
  logic [0:0]      resp_id;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_c_i(alu_c), .alu_cmp_i(alu_cmp),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_cmp_o(resp_cmp),
    .resp_id_o(resp_id), .resp_err_o(resp_err)
  );

  // Small ALU stand-in: {cmp, result}. Unlisted opcodes give a recognisable
  // nonzero value, so a missed illegal-opcode squash shows up.
  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [4:0] op);
    logic [31:0] w;
    case (op)
      5'd0:  return {(a == b), a + b};
      5'd1:  return {(a == b), a - b};
      5'd4:  return {(a == b), a ^ b};
      5'd9:  return {($signed(a) < $signed(b)), {63'd0, ($signed(a) < $signed(b))}};
      5'd13: begin
        w = a[31:0] - b[31:0];
        return {(a == b), {{32{w[31]}}, w}};
      end
      default: return {(a == b), a + b + {59'd0, op}};
    endcase
  endfunction

  always_comb {alu_cmp, alu_c} = alu_fn(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] op);
    req_valid[idx] = 1'b1;
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req_op[idx*5 +: 5] = op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [4:0]    op;
    logic [DW-1:0] data;
    logic          cmp;
    logic          err;
  } vec_t;

  vec_t vecs[6];

  // One isolated transaction: grant in t, EXEC in t+1, response in t+2.
  task automatic run_vec(input int k, input vec_t v);
    int waitc;
    logic [N-1:0] one;
    one = '0;
    one[v.req] = 1'b1;
    @(negedge clk);
    req_valid = '0;
    set_req(v.req, v.a, v.b, v.op);
    resp_ready = 1'b1;
    #1;
    waitc = 0;
    while (req_ready == '0 && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check($sformatf("vec%0d grant", k), req_ready, one);
    @(negedge clk);
    req_valid = '0;
    check($sformatf("vec%0d exec alu_op", k), alu_op, v.op);
    check($sformatf("vec%0d exec alu_a", k), alu_a, v.a);
    check($sformatf("vec%0d exec no resp", k), resp_valid, 0);
    @(negedge clk);
    #1;
    check($sformatf("vec%0d resp_valid", k), resp_valid, 1);
    check($sformatf("vec%0d data", k), resp_data, v.data);
    check($sformatf("vec%0d cmp", k), resp_cmp, v.cmp);
    check($sformatf("vec%0d id", k), resp_id, v.req);
    check($sformatf("vec%0d err", k), resp_err, v.err);
    $display("vec%0d req=%0d op=%0d a=%h b=%h -> data=%h cmp=%0d err=%0d",
             k, v.req, v.op, v.a, v.b, resp_data, resp_cmp, resp_err);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int ngr, nresp, mptr, resp_cyc, w, last_w;
    bit busy, exp_valid, window;
    logic [DW:0] r;
    logic [DW-1:0] exp_data, a, b;
    logic exp_cmp, exp_err;
    logic [4:0] op;
    int exp_id;
    logic [N-1:0] exp_ready;

    vecs[0] = '{0, 64'd5, 64'd7, 5'd0, 64'd12, 1'b0, 1'b0};
    vecs[1] = '{1, 64'd0, 64'd1, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd9, 64'd1, 1'b1, 1'b0};
    vecs[3] = '{1, 64'd3, 64'd3, 5'd17, 64'd0, 1'b0, 1'b1};
    vecs[4] = '{0, 64'hF0, 64'hFF, 5'd4, 64'h0F, 1'b0, 1'b0};
    vecs[5] = '{1, 64'd9, 64'd9, 5'd1, 64'd0, 1'b1, 1'b0};

    req_a = '0; req_b = '0; req_op = '0;
    do_reset();
    #1;
    check("reset resp_valid", resp_valid, 0);
    check("reset alu_a", alu_a, 0);
    check("reset alu_op", alu_op, 0);
    check("reset resp_data", resp_data, 0);
    check("reset resp_id", resp_id, 0);

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Backpressure: response held for 5 cycles, then fire and accept together.
    @(negedge clk);
    req_valid = '0;
    resp_ready = 1'b0;
    set_req(0, 64'd1, 64'd2, 5'd0);
    #1;
    check("bp grant", req_ready, 2'b01);
    @(negedge clk);
    set_req(0, 64'd10, 64'd20, 5'd0);
    #1;
    check("bp exec ready", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp hold%0d valid", k), resp_valid, 1);
      check($sformatf("bp hold%0d data", k), resp_data, 64'd3);
      check($sformatf("bp hold%0d ready", k), req_ready, 0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    check("bp fire+accept ready", req_ready, 2'b01);
    check("bp fire valid", resp_valid, 1);
    @(negedge clk);
    req_valid = '0;
    check("bp exec after fire", resp_valid, 0);
    check("bp exec alu_a", alu_a, 64'd10);
    @(negedge clk);
    check("bp second resp", resp_valid, 1);
    check("bp second data", resp_data, 64'd30);
    $display("backpressure sequence done");

    // Round-robin with both requesters valid continuously.
    do_reset();
    set_req(0, 64'd100, 64'd1, 5'd0);
    set_req(1, 64'd200, 64'd2, 5'd0);
    resp_ready = 1'b1;
    ngr = 0;
    nresp = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != '0) begin
        exp_ready = '0;
        exp_ready[ngr % 2] = 1'b1;
        check($sformatf("rr grant%0d", ngr), req_ready, exp_ready);
        check($sformatf("rr grant%0d cycle", ngr), c, 2 * ngr);
        ngr++;
      end
      if (resp_valid) begin
        check($sformatf("rr resp%0d id", nresp), resp_id, nresp % 2);
        check($sformatf("rr resp%0d data", nresp), resp_data, (nresp % 2) ? 64'd202 : 64'd101);
        check($sformatf("rr resp%0d cycle", nresp), c, 2 * nresp + 2);
        $display("rr cycle %0d resp id=%0d data=%0d", c, resp_id, resp_data);
        nresp++;
      end
      @(negedge clk);
    end
    check("rr grant count", ngr, 6);
    check("rr resp count", nresp, 5);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Reset during EXEC drops the operation; first grant afterwards is index 0.
    set_req(0, 64'd3, 64'd4, 5'd0);
    #1;
    check("rst pre grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_data", resp_data, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_b", alu_b, 0);
    check("rst resp_id", resp_id, 0);
    check("rst resp_err", resp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 64'd1, 64'd1, 5'd0);
    set_req(1, 64'd2, 64'd2, 5'd0);
    #1;
    check("rst first grant", req_ready, 2'b01);
    check("rst no stale resp", resp_valid, 0);
    @(negedge clk);
    req_valid = '0;
    check("rst no stale resp exec", resp_valid, 0);
    repeat (3) @(negedge clk);
    $display("reset sequence done");

    // Randomized traffic against a transaction-level model.
    do_reset();
    busy = 0;
    mptr = 0;
    resp_cyc = 0;
    last_w = -1;
    exp_data = '0; exp_cmp = 0; exp_err = 0; exp_id = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (last_w >= 0) req_valid[last_w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          a = {$urandom, $urandom};
          b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
          op = 5'($urandom_range(0, 31));
          set_req(i, a, b, op);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_valid = busy && (cyc >= resp_cyc);
      window = !busy || (exp_valid && resp_ready);
      w = window ? rr_pick(req_valid, mptr) : -1;
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      check($sformatf("rand c%0d ready", cyc), req_ready, exp_ready);
      check($sformatf("rand c%0d valid", cyc), resp_valid, exp_valid);
      if (exp_valid) begin
        check($sformatf("rand c%0d data", cyc), resp_data, exp_data);
        check($sformatf("rand c%0d cmp", cyc), resp_cmp, exp_cmp);
        check($sformatf("rand c%0d id", cyc), resp_id, exp_id);
        check($sformatf("rand c%0d err", cyc), resp_err, exp_err);
        if (resp_ready)
          $display("rand c%0d resp id=%0d data=%h cmp=%0d err=%0d",
                   cyc, resp_id, resp_data, resp_cmp, resp_err);
      end
      if (exp_valid && resp_ready) busy = 0;
      if (w >= 0) begin
        a = req_a[w*DW +: DW];
        b = req_b[w*DW +: DW];
        op = req_op[w*5 +: 5];
        busy = 1;
        resp_cyc = cyc + 2;
        exp_id = w;
        if (op > 5'd16) begin
          exp_data = '0; exp_cmp = 1'b0; exp_err = 1'b1;
        end else begin
          r = alu_fn(a, b, op);
          exp_data = r[DW-1:0]; exp_cmp = r[DW]; exp_err = 1'b0;
        end
        mptr = (w + 1) % N;
      end
      last_w = w;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
